// File: rtl/scan_seq_2b.sv
// Two-bit select sequencer for a 2-to-4 decoder: prescaled
// auto-scan, manual step and direct load, with pulse flags.
module scan_seq_2b #(
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             DIR,
  input  logic [DIV_W-1:0] DIV,
  input  logic             STEP,
  input  logic             LD,
  input  logic [1:0]       LD_VAL,
  output logic             I1,
  output logic             I0,
  output logic             TICK,
  output logic             WRAP,
  output logic             BLK
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] pc;
  logic [DIV_W-1:0] pc_nx;
  logic [1:0]       sel;
  logic [1:0]       sel_nx;
  logic             adv;
  logic             wrap_nx;

  always_comb begin
    state_nx = EN ? RUN : IDLE;
    pc_nx    = DIV;
    sel_nx   = sel;
    adv      = 1'b0;
    wrap_nx  = 1'b0;
    unique case (state)
      IDLE: adv = STEP && !EN;
      RUN: begin
        if (EN) begin
          if (pc == '0) adv = 1'b1;
          else pc_nx = pc - 1'b1;
        end
      end
      default: adv = 1'b0;
    endcase
    // A load wins over any advance on the same edge; the advance is lost.
    if (LD) begin
      adv    = 1'b0;
      sel_nx = LD_VAL;
      pc_nx  = DIV;
    end else if (adv) begin
      sel_nx  = DIR ? sel - 2'd1 : sel + 2'd1;
      wrap_nx = DIR ? (sel == 2'b00) : (sel == 2'b11);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      pc    <= '0;
      sel   <= 2'b00;
      TICK  <= 1'b0;
      WRAP  <= 1'b0;
      BLK   <= 1'b0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      sel   <= sel_nx;
      TICK  <= adv;
      WRAP  <= wrap_nx;
      BLK   <= adv | LD;
    end
  end

  assign I1 = sel[1];
  assign I0 = sel[0];

endmodule

// File: tb/tb_scan_seq_2b.sv
// Bench for scan_seq_2b: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_scan_seq_2b;

  logic       clk = 1'b0;
  logic       rst, en, dir, step, ld;
  logic [7:0] div;
  logic [1:0] ld_val;
  logic       i1, i0, tick, wrap, blk;

  int errors = 0;
  int checks = 0;

  // behavioural model
  bit m_run;
  int m_left;
  int m_sel;
  bit m_tick, m_wrap, m_blk;

  scan_seq_2b #(.DIV_W(8)) dut (
    .CLK(clk), .RST(rst), .EN(en), .DIR(dir), .DIV(div),
    .STEP(step), .LD(ld), .LD_VAL(ld_val),
    .I1(i1), .I0(i0), .TICK(tick), .WRAP(wrap), .BLK(blk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Edges remaining until the next auto-advance is tracked as m_left.
  task automatic model_edge();
    bit adv;
    bit wr;
    adv = 0;
    wr  = 0;
    if (rst) begin
      m_run = 0; m_left = 1; m_sel = 0;
      m_tick = 0; m_wrap = 0; m_blk = 0;
      return;
    end
    if (m_run && en && !ld) begin
      if (m_left == 1) adv = 1;
      else m_left = m_left - 1;
    end
    if (!m_run && !en && step && !ld) adv = 1;
    if (ld || !(m_run && en) || adv) m_left = int'(div) + 1;
    if (ld) m_sel = int'(ld_val);
    else if (adv) begin
      wr = dir ? (m_sel == 0) : (m_sel == 3);
      m_sel = dir ? (m_sel + 3) % 4 : (m_sel + 1) % 4;
    end
    m_tick = adv;
    m_wrap = wr;
    m_blk  = adv || ld;
    m_run  = en;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("sel",  int'({i1, i0}), m_sel);
    chk("tick", int'(tick), int'(m_tick));
    chk("wrap", int'(wrap), int'(m_wrap));
    chk("blk",  int'(blk),  int'(m_blk));
  endtask

  task automatic idle_in();
    en = 0; dir = 0; step = 0; ld = 0; ld_val = 0;
  endtask

  initial begin
    rst = 1; en = 1; ld = 1; step = 1; dir = 0;
    div = 8'd3; ld_val = 2'b10;
    m_run = 0; m_left = 1; m_sel = 0;
    m_tick = 0; m_wrap = 0; m_blk = 0;

    // reset overrides EN/LD/STEP
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_sel",  int'({i1, i0}), 0);
      chk("rst_flag", int'({tick, wrap, blk}), 0);
    end

    // up scan, DIV=3
    rst = 0; ld = 0; step = 0; en = 1; dir = 0; div = 8'd3;
    for (int i = 0; i < 5; i++) cyc();
    chk("up_first_sel",  int'({i1, i0}), 1);
    chk("up_first_tick", int'(tick), 1);
    cyc();
    chk("up_hold_tick", int'(tick), 0);
    chk("up_hold_sel",  int'({i1, i0}), 1);
    for (int i = 0; i < 11; i++) cyc();
    chk("up_wrap_sel", int'({i1, i0}), 0);
    chk("up_wrap",     int'(wrap), 1);

    // load at pc==0 edge suppresses the advance
    for (int i = 0; i < 3; i++) cyc();
    ld = 1; ld_val = 2'b10;
    cyc();
    ld = 0;
    chk("ld_sel",  int'({i1, i0}), 2);
    chk("ld_tick", int'(tick), 0);
    chk("ld_blk",  int'(blk), 1);
    for (int i = 0; i < 4; i++) cyc();
    chk("ld_next_sel", int'({i1, i0}), 3);

    // manual steps from 10
    idle_in();
    ld = 1; ld_val = 2'b10;
    cyc();
    ld = 0;
    step = 1; cyc(); step = 0;
    chk("step1", int'({i1, i0}), 3);
    cyc();
    step = 1; cyc(); step = 0;
    chk("step2",      int'({i1, i0}), 0);
    chk("step2_wrap", int'(wrap), 1);
    cyc();
    step = 1; cyc(); step = 0;
    chk("step3", int'({i1, i0}), 1);
    cyc();

    // down scan, DIV=0
    rst = 1; cyc(); rst = 0;
    en = 1; dir = 1; div = 8'd0;
    cyc();
    cyc();
    chk("dn_sel1",  int'({i1, i0}), 3);
    chk("dn_wrap1", int'(wrap), 1);
    cyc();
    chk("dn_sel2",  int'({i1, i0}), 2);
    chk("dn_tick2", int'(tick), 1);
    chk("dn_wrap2", int'(wrap), 0);
    cyc(); cyc();
    chk("dn_sel4", int'({i1, i0}), 0);

    // reset mid-scan, restart with DIV=2
    dir = 0; div = 8'd2;
    rst = 1; cyc(); rst = 0;
    chk("mid_rst_sel", int'({i1, i0}), 0);
    cyc();
    cyc(); cyc();
    chk("restart_hold", int'({i1, i0}), 0);
    cyc();
    chk("restart_sel", int'({i1, i0}), 1);

    // randomized run
    for (int n = 0; n < 4000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      ld     = ($urandom_range(0, 9) == 0);
      ld_val = 2'($urandom_range(0, 3));
      step   = ($urandom_range(0, 2) == 0);
      dir    = ($urandom_range(0, 5) == 0) ? ~dir : dir;
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) div = 8'($urandom_range(0, 5));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_seq_2b.md
SCAN_SEQ_2B -- requirements
Module: scan_seq_2b

Interface
REQ-001 The module SHALL have parameter DIV_W, default 8, giving the prescaler reload width.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 EN  input  1  run enable; 1 = auto-scan, 0 = idle/manual step.
REQ-005 DIR  input  1  scan direction; 0 = up (00->01->10->11), 1 = down.
REQ-006 DIV  input  DIV_W  prescale reload; auto-advance every DIV+1 cycles.
REQ-007 STEP  input  1  manual advance request, honoured only while idle.
REQ-008 LD  input  1  load request for the select value.
REQ-009 LD_VAL  input  2  value loaded into {I1,I0} when LD=1.
REQ-010 I1  output  1  registered select MSB, drives 2-to-4 decoder I1.
REQ-011 I0  output  1  registered select LSB, drives 2-to-4 decoder I0.
REQ-012 TICK  output  1  one-cycle pulse on every cycle where the select advanced.
REQ-013 WRAP  output  1  one-cycle pulse when an advance wrapped (up 11->00, down 00->11).
REQ-014 BLK  output  1  one-cycle blanking pulse whenever {I1,I0} changes value or is loaded.

Function
REQ-015 State machine SHALL have two states: IDLE and RUN; IDLE->RUN on edge with EN=1, RUN->IDLE on edge with EN=0.
REQ-016 In IDLE, prescaler counter pc SHALL reload DIV every cycle; select holds unless STEP or LD.
REQ-017 In RUN with EN=1, each edge: if pc==0 then advance select, pc<=DIV; else pc<=pc-1.
REQ-018 First auto-advance SHALL occur DIV+1 edges after the edge that enters RUN; period thereafter DIV+1 cycles.
REQ-019 DIV=0 SHALL advance every cycle in RUN; DIV changes take effect at the next reload only.
REQ-020 Advance SHALL be modulo-4: +1 when DIR=0, -1 when DIR=1, DIR sampled on the advancing edge.
REQ-021 STEP=1 in IDLE (and EN=0) SHALL advance select once per cycle STEP is high; STEP SHALL be ignored in RUN.
REQ-022 LD=1 SHALL set {I1,I0}<=LD_VAL and pc<=DIV on that edge, in either state.
REQ-023 Priority on a single edge: RST > LD > (auto-advance or STEP); a suppressed advance is lost, not deferred.
REQ-024 TICK SHALL be 1 in the cycle after an advancing edge; 0 after a load-only edge.
REQ-025 WRAP SHALL be 1 only together with TICK and only for a wrapping advance.
REQ-026 BLK SHALL be 1 for exactly one cycle after any advancing or loading edge, including LD_VAL equal to current value.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-028 A LD or advance on consecutive edges SHALL produce BLK/TICK high on consecutive cycles without gaps.

Reset
REQ-029 RST=1 at an edge SHALL force state IDLE, pc=0, I1=0, I0=0, TICK=0, WRAP=0, BLK=0, overriding EN, STEP and LD.
REQ-030 Reset mid-run SHALL discard prescaler progress; after release, scanning restarts from 00 per REQ-018.

Verification
REQ-031 RST=1 for 2 cycles with EN=1, LD=1, STEP=1 -> I1I0=00, TICK=WRAP=BLK=0 every cycle of reset.
REQ-032 EN=1, DIR=0, DIV=3 -> I1I0 = 00,01,10,11,00 each held 4 cycles; TICK and BLK pulse per change; WRAP only on 11->00.
REQ-033 EN=1, DIR=1, DIV=0 -> I1I0 = 00,11,10,01,00 changing every cycle; TICK held high; WRAP only on 00->11.
REQ-034 Running DIV=3, LD=1 with LD_VAL=10 on an edge where pc==0 -> I1I0=10, TICK=0, BLK=1, next advance 4 cycles later to 11.
REQ-035 EN=0, three single-cycle STEP pulses with DIR=0 from 10 -> 11, 00 (WRAP=1), 01; STEP with EN=1 -> no change outside normal prescale.
REQ-036 RST asserted mid-scan at I1I0=11 -> 00 next cycle; after release with EN=1, DIV=2 -> first advance to 01 three edges after entering RUN.
